line_delay_ctrl: RTL and testbench

LINE_DELAY_CTRL -- requirements
Module: line_delay_ctrl

---
 rtl/line_delay_ctrl.sv | 141 ++++++++++++++
 tb/tb_line_delay_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_delay_ctrl
// Description : Pairs each incoming pixel with the pixel in the same column
//               of the previous line. An external single-port read_first
//               line RAM with a two-cycle read latency stores the line.
//               Every write returns the old contents of that column, and a
//               two-stage pipeline re-aligns the current pixel with that data.
// Revision    : 1.0 - initial release
// ============================================================================
module line_delay_ctrl #(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_LINE_WIDTH = 640,
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    clka,
    input  logic                    rsta_n,
    input  logic                    s_vsync,
    input  logic                    s_valid,
    input  logic [P_DATA_WIDTH-1:0] s_data,
    output logic                    ram_ena,
    output logic                    ram_wea,
    output logic [P_ADDR_WIDTH-1:0] ram_addra,
    output logic [P_DATA_WIDTH-1:0] ram_dina,
    input  logic [P_DATA_WIDTH-1:0] ram_douta,
    output logic                    m_valid,
    output logic [P_DATA_WIDTH-1:0] m_cur,
    output logic [P_DATA_WIDTH-1:0] m_prev,
    output logic                    m_prev_valid,
    output logic [P_ADDR_WIDTH-1:0] m_col,
    output logic                    m_eol
);

    localparam logic [P_ADDR_WIDTH-1:0] C_LAST_COL = P_ADDR_WIDTH'(P_LINE_WIDTH - 1);
    localparam logic [P_ADDR_WIDTH-1:0] C_ONE      = P_ADDR_WIDTH'(1);

    // Column counter and first-line flag for the pixel that arrives next
    logic [P_ADDR_WIDTH-1:0] r_col;
    logic                    r_first;

    // A frame start in the same cycle as a pixel makes that pixel column 0
    // of a first line. Use these resolved values everywhere.
    logic [P_ADDR_WIDTH-1:0] w_col;
    logic                    w_first;
    logic                    w_eol;

    // Stage 1 of the pipeline, aligned with the RAM's internal read register
    logic                    r_v1;
    logic [P_DATA_WIDTH-1:0] r_d1;
    logic [P_ADDR_WIDTH-1:0] r_col1;
    logic                    r_fl1;
    logic                    r_eol1;

    // Stage 2 of the pipeline, aligned with ram_douta
    logic                    r_v2;
    logic [P_DATA_WIDTH-1:0] r_d2;
    logic [P_ADDR_WIDTH-1:0] r_col2;
    logic                    r_fl2;
    logic                    r_eol2;

    assign w_col   = s_vsync ? '0 : r_col;
    assign w_first = s_vsync | r_first;
    assign w_eol   = (w_col == C_LAST_COL);

    // The RAM is driven straight from the input. Gating it with the reset
    // keeps the RAM from being written while the block is held in reset.
    assign ram_ena   = s_valid & rsta_n;
    assign ram_wea   = s_valid & rsta_n;
    assign ram_addra = w_col;
    assign ram_dina  = s_data;

    // Advance the column on each pixel, wrap at end of line, and restart on frame start
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_col   <= '0;
            r_first <= 1'b1;
        end else if (s_valid) begin
            if (w_eol) begin
                r_col   <= '0;
                r_first <= 1'b0;
            end else begin
                r_col   <= w_col + C_ONE;
                r_first <= w_first;
            end
        end else if (s_vsync) begin
            r_col   <= '0;
            r_first <= 1'b1;
        end
    end

    // Shift the valid strobes every cycle so that gaps in the input are kept
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= s_valid;
            r_v2 <= r_v1;
        end
    end

    // Capture the pixel attributes in stage 1 only on a valid beat
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_d1   <= '0;
            r_col1 <= '0;
            r_fl1  <= 1'b1;
            r_eol1 <= 1'b0;
        end else if (s_valid) begin
            r_d1   <= s_data;
            r_col1 <= w_col;
            r_fl1  <= w_first;
            r_eol1 <= w_eol;
        end
    end

    // Move the attributes to stage 2 on a valid beat; otherwise hold them for the output
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_d2   <= '0;
            r_col2 <= '0;
            r_fl2  <= 1'b1;
            r_eol2 <= 1'b0;
        end else if (r_v1) begin
            r_d2   <= r_d1;
            r_col2 <= r_col1;
            r_fl2  <= r_fl1;
            r_eol2 <= r_eol1;
        end
    end

    // On the first line of a frame the RAM contents are stale, so mask them
    assign m_valid      = r_v2;
    assign m_cur        = r_d2;
    assign m_col        = r_col2;
    assign m_eol        = r_eol2;
    assign m_prev_valid = r_v2 & ~r_fl2;
    assign m_prev       = m_prev_valid ? ram_douta : '0;

endmodule
`default_nettype wire

// File: tb/tb_line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_delay_ctrl
// Description : Self-checking bench for line_delay_ctrl. It includes a
//               read_first, latency-2 line RAM and a per-pixel reference
//               model of the expected output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_delay_ctrl;

    localparam int C_DW = 16;
    localparam int C_LW = 4;
    localparam int C_AW = 10;

    logic            clka;
    logic            rsta_n;
    logic            s_vsync;
    logic            s_valid;
    logic [C_DW-1:0] s_data;
    logic            ram_ena;
    logic            ram_wea;
    logic [C_AW-1:0] ram_addra;
    logic [C_DW-1:0] ram_dina;
    logic [C_DW-1:0] ram_douta;
    logic            m_valid;
    logic [C_DW-1:0] m_cur;
    logic [C_DW-1:0] m_prev;
    logic            m_prev_valid;
    logic [C_AW-1:0] m_col;
    logic            m_eol;

    int errors = 0;
    int checks = 0;

    line_delay_ctrl #(
        .P_DATA_WIDTH (C_DW),
        .P_LINE_WIDTH (C_LW),
        .P_ADDR_WIDTH (C_AW)
    ) dut (
        .clka         (clka),
        .rsta_n       (rsta_n),
        .s_vsync      (s_vsync),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .ram_ena      (ram_ena),
        .ram_wea      (ram_wea),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_douta    (ram_douta),
        .m_valid      (m_valid),
        .m_cur        (m_cur),
        .m_prev       (m_prev),
        .m_prev_valid (m_prev_valid),
        .m_col        (m_col),
        .m_eol        (m_eol)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Line RAM: single-port, read_first, read latency 2
    logic [C_DW-1:0] ram_mem [0:(1<<C_AW)-1];
    logic [C_DW-1:0] ram_rd1;
    logic [C_DW-1:0] ram_rd2;
    initial begin
        for (int i = 0; i < (1 << C_AW); i++) ram_mem[i] = '0;
        ram_rd1 = '0;
        ram_rd2 = '0;
    end
    always @(posedge clka) begin
        if (ram_ena) begin
            ram_rd1 <= ram_mem[ram_addra];
            if (ram_wea) ram_mem[ram_addra] <= ram_dina;
        end
        ram_rd2 <= ram_rd1;
    end
    assign ram_douta = ram_rd2;

    // Reference model: the last pixel written to each column, plus the
    // position in the line and first-line status of the next pixel
    typedef struct {
        logic            v;
        logic            first;
        logic            eol;
        int              col;
        logic [C_DW-1:0] d;
        logic [C_DW-1:0] prev;
    } rec_t;

    logic [C_DW-1:0] last_px [0:C_LW-1];
    int   mdl_col;
    logic mdl_first;
    rec_t e1, e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e1.v = 1'b0;
        e2.v = 1'b0;
        mdl_col = 0;
        mdl_first = 1'b1;
    endtask

    task automatic model_clock(input logic v, input logic vs, input logic [C_DW-1:0] d);
        rec_t r;
        r.v = v; r.first = 1'b0; r.eol = 1'b0; r.col = 0; r.d = d; r.prev = '0;
        if (v) begin
            r.col   = vs ? 0 : mdl_col;
            r.first = vs | mdl_first;
            r.eol   = (r.col == C_LW - 1);
            r.prev  = r.first ? '0 : last_px[r.col];
            last_px[r.col] = d;
            if (r.eol) begin
                mdl_col = 0;
                mdl_first = 1'b0;
            end else begin
                mdl_col = r.col + 1;
                mdl_first = r.first;
            end
        end else if (vs) begin
            mdl_col = 0;
            mdl_first = 1'b1;
        end
        e2 = e1;
        e1 = r;
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(m_valid), 32'(e2.v));
        chk("m_prev_valid", 32'(m_prev_valid), 32'(e2.v & ~e2.first));
        chk("m_prev", 32'(m_prev), (e2.v && !e2.first) ? 32'(e2.prev) : 32'd0);
        if (e2.v) begin
            chk("m_cur", 32'(m_cur), 32'(e2.d));
            chk("m_col", 32'(m_col), 32'(e2.col));
            chk("m_eol", 32'(m_eol), 32'(e2.eol));
        end
    endtask

    // One clock cycle: drive the inputs, check the RAM port, clock, then check the outputs
    task automatic step(input logic v, input logic vs, input logic [C_DW-1:0] d);
        s_valid = v;
        s_vsync = vs;
        s_data  = d;
        #1;
        chk("ram_ena", 32'(ram_ena), 32'(v));
        chk("ram_wea", 32'(ram_wea), 32'(v));
        if (v) begin
            chk("ram_addra", 32'(ram_addra), vs ? 32'd0 : 32'(mdl_col));
            chk("ram_dina", 32'(ram_dina), 32'(d));
        end
        @(posedge clka);
        model_clock(v, vs, d);
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        s_valid = 1'b1;
        s_vsync = 1'b0;
        s_data  = 16'hDEAD;
        rsta_n  = 1'b0;
        #1;
        model_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_prev_valid", 32'(m_prev_valid), 32'd0);
        chk("rst_m_eol", 32'(m_eol), 32'd0);
        chk("rst_m_cur", 32'(m_cur), 32'd0);
        chk("rst_m_prev", 32'(m_prev), 32'd0);
        chk("rst_m_col", 32'(m_col), 32'd0);
        chk("rst_ram_ena", 32'(ram_ena), 32'd0);
        chk("rst_ram_wea", 32'(ram_wea), 32'd0);
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < C_LW; i++) last_px[i] = '0;
        model_reset();
        rsta_n  = 1'b0;
        s_valid = 1'b0;
        s_vsync = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clka);
        #1;
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_prev_valid", 32'(m_prev_valid), 32'd0);
        chk("reset_m_col", 32'(m_col), 32'd0);
        chk("reset_ram_ena", 32'(ram_ena), 32'd0);
        rsta_n = 1'b1;

        // Frame start, then two back-to-back lines: pixels 1..8
        step(1'b0, 1'b1, 16'd0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i));
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);

        // New frame, then s_valid toggling over one line, followed by a full line
        step(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 8; i++) step((i % 2) == 0, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0200 + i));

        // Two pixels of a line, a frame start alone, then the next pixel is column 0
        step(1'b1, 1'b0, 16'h0301);
        step(1'b1, 1'b0, 16'h0302);
        step(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h0400 + i));

        // Reset pulsed mid-line, then the next line starts at column 0
        step(1'b1, 1'b0, 16'h0501);
        step(1'b1, 1'b0, 16'h0502);
        reset_pulse();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h0600 + i));

        // Frame start and a pixel in the same cycle
        step(1'b1, 1'b0, 16'h0701);
        step(1'b1, 1'b1, 16'h0702);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'(16'h0800 + i));
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);

        // Randomized traffic with occasional frame starts and resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 16'($urandom));
            end
        end
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
